wb_merge_unit: RTL and testbench
================================

Name: wb_merge_unit

Overview:
- Write-back stage that produces the single register-file write port (write_back_ifc: uses_rw, rw_addr, rw_data).
- Merges two result sources into one write per cycle:
  - ALU/non-memory results, which cannot stall.
  - Memory load results, which are buffered in a small in-order queue.
- Also reports which architectural registers have writes still pending, so decode can stall on RAW hazards.

Parameters:
- LOAD_Q_DEPTH, 4: load-result queue entries; power of two, minimum 2.
- REG_ADDR_W, 5: register address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result present this cycle; always accepted.
- alu_rw_addr  in  REG_ADDR_W  ALU destination register.
- alu_rw_data  in  `DATA_WIDTH  ALU result.
- mem_valid  in  1  load result offered.
- mem_ready  out  1  queue can accept a load result.
- mem_rw_addr  in  REG_ADDR_W  load destination register.
- mem_rw_data  in  `DATA_WIDTH  load data.
- q_rs_addr  in  REG_ADDR_W  hazard query A.
- q_rt_addr  in  REG_ADDR_W  hazard query B.
- q_rs_pending  out  1  a write to q_rs_addr is queued or in the output register.
- q_rt_pending  out  1  a write to q_rt_addr is queued or in the output register.
- o_wb  out  write_back_ifc  registered write port to the register file.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - o_wb: uses_rw=0, rw_addr=0, rw_data=0.
  - Queue is empty; head pointer = tail pointer = 0; count = 0.
  - mem_ready=0 while rst_n is low.
  - q_*_pending=0.
- Transfers:
  - A load transfer occurs when mem_valid & mem_ready at the clock edge.
  - mem_ready = (count < LOAD_Q_DEPTH). It is registered-count based and never combinationally dependent on mem_valid.
  - The load source holds addr/data until the transfer.
- Output selection each cycle (registered, so o_wb updates on the next edge):
  - ALU path: if alu_valid, o_wb <= {1, alu_rw_addr, alu_rw_data}. ALU results have absolute priority, so ALU latency is 1.
  - Load path: otherwise, if the queue is non-empty, pop the head and o_wb <= {head.live, head.addr, head.data}.
  - Idle: otherwise o_wb.uses_rw <= 0; addr and data hold their previous values.
- Register zero: any write with addr==0 drives uses_rw=0 and is never reported pending.
- Squash (program order):
  - A load transfer is older than any ALU result in the same or a later cycle.
  - An accepted alu_valid write clears the live bit of every queued entry with the same addr, including an entry enqueued in the same cycle.
  - Squashed entries still pop in order but emit uses_rw=0.
- Full queue, simultaneous events:
  - When count==LOAD_Q_DEPTH, mem_ready=0, even if a pop happens in the same cycle.
  - Enqueue and pop in the same cycle leave count unchanged.
- Pointers wrap modulo LOAD_Q_DEPTH.
- Pending flags (combinational):
  - q_x_pending = OR over live queue entries with addr==q_x_addr, OR (o_wb.uses_rw & o_wb.rw_addr==q_x_addr).
  - Forced to 0 for q_x_addr==0.
- Reset mid-operation: queued entries are discarded and no write is emitted after rst_n deasserts.

Optional Feature:
- Macro: WB_LOAD_BYPASS_EN.
- Defined: if the queue is empty, alu_valid=0, and a load transfer occurs, the load goes directly into o_wb on that edge without being enqueued. Load latency is 1.
- Undefined: every load is enqueued first, so minimum load latency is 2 cycles (enqueue, then pop into o_wb).

Decomposition:
- Shared mips_core package gets:
  - typedef wb_entry_t {logic live; logic [REG_ADDR_W-1:0] addr; logic [`DATA_WIDTH-1:0] data;}
  - constant REG_ZERO = 0.
- One natural sub-module: wb_load_queue.
  - Holds storage, pointers, count, the squash-by-address port, and per-entry live/addr vectors for the pending lookup.
  - The top level holds output muxing and the bypass.

Test Plan:
- ALU only: alu_valid with r3=0xDEADBEEF at cycle N -> o_wb={1,3,0xDEADBEEF} at N+1; uses_rw=0 at N+2 if idle.
- Load under ALU pressure:
  - Stimulus: loads r4=0x11 and r5=0x22 accepted while alu_valid is high for 3 cycles writing r7.
  - Response: three r7 writes, then r4, then r5, in order; q_rs_pending(r5)=1 until the r5 write leaves o_wb.
- Full/back-pressure:
  - Stimulus: LOAD_Q_DEPTH=4 with ALU busy.
  - Response: 4 loads accepted and mem_ready=0 on the 5th. The 5th is accepted only after the first pop, and no data is lost or duplicated.
- Squash:
  - Stimulus: load r6=0xAA queued, then ALU writes r6=0xBB.
  - Response: o_wb emits r6=0xBB, and the popped load slot shows uses_rw=0; final r6 is 0xBB.
  - Same-cycle variant gives the same result.
- Register zero: ALU write to r0 and load to r0 -> uses_rw never asserted; q_rs_pending(0)=0.
- Reset mid-operation:
  - Stimulus: 3 loads queued, rst_n pulsed low asynchronously between edges.
  - Response: outputs are immediately at reset values; no stale write after release.
  - Bypass builds only: an idle load appears on o_wb 1 cycle after transfer.

Source files
------------

// File: rtl/wb_merge_unit_pkg.sv
// Shared types for the write-back merge unit.
//   wb_entry_t     : one load-queue slot (live flag, destination, data)
//   write_back_ifc : register-file write port (uses_rw, rw_addr, rw_data)
// `DATA_WIDTH defaults to 32 when the includer has not set it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package wb_merge_unit_pkg;

   localparam int WB_REG_ADDR_W = 5;

   localparam logic [WB_REG_ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic                     live;
      logic [WB_REG_ADDR_W-1:0] addr;
      logic [`DATA_WIDTH-1:0]   data;
   } wb_entry_t;

   typedef struct packed {
      logic                     uses_rw;
      logic [WB_REG_ADDR_W-1:0] rw_addr;
      logic [`DATA_WIDTH-1:0]   rw_data;
   } write_back_ifc;

endpackage

// File: rtl/wb_load_queue.sv
// In-order load-result queue for wb_merge_unit.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_push/i_push_entry  enqueue one entry (caller guarantees o_ready)
//   i_pop             dequeue head (caller guarantees !o_empty)
//   i_squash_en/addr  clear live bit of every slot holding that destination,
//                     including the slot being written this cycle
//   o_head            head entry
//   o_empty, o_ready  count==0, count<DEPTH
//   o_live_vec/o_addr_vec  per-slot live/addr for hazard lookup
module wb_load_queue
   import wb_merge_unit_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                i_push,
   input  wb_entry_t                           i_push_entry,
   input  logic                                i_pop,
   input  logic                                i_squash_en,
   input  logic [WB_REG_ADDR_W-1:0]            i_squash_addr,
   output wb_entry_t                           o_head,
   output logic                                o_empty,
   output logic                                o_ready,
   output logic [DEPTH-1:0]                    o_live_vec,
   output logic [DEPTH-1:0][WB_REG_ADDR_W-1:0] o_addr_vec
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t [DEPTH-1:0] r_mem;
   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic [CW-1:0]         r_count;

   // Live bits are cleared on pop so that only occupied slots can ever
   // report a pending write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem   <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_squash_en && (r_mem[i].addr == i_squash_addr))
               r_mem[i].live <= 1'b0;
         end
         if (i_pop) begin
            r_mem[r_head].live <= 1'b0;
            r_head             <= PW'(r_head + 1'b1);
         end
         if (i_push) begin
            r_mem[r_tail].live <= i_push_entry.live &
                                  ~(i_squash_en && (i_squash_addr == i_push_entry.addr));
            r_mem[r_tail].addr <= i_push_entry.addr;
            r_mem[r_tail].data <= i_push_entry.data;
            r_tail             <= PW'(r_tail + 1'b1);
         end
         if (i_push && !i_pop)
            r_count <= r_count + CW'(1);
         else if (i_pop && !i_push)
            r_count <= r_count - CW'(1);
      end
   end

   assign o_head  = r_mem[r_head];
   assign o_empty = (r_count == '0);
   assign o_ready = (r_count < CW'(DEPTH));

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         o_live_vec[i] = r_mem[i].live;
         o_addr_vec[i] = r_mem[i].addr;
      end
   end

endmodule

// File: rtl/wb_merge_unit.sv
// Write-back merge unit: merges non-stallable ALU results and queued load
// results into one registered register-file write port, and reports
// pending writes for RAW hazard detection.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   alu_valid/alu_rw_addr/alu_rw_data  ALU result, always accepted
//   mem_valid/mem_ready/mem_rw_addr/mem_rw_data  load result handshake
//   q_rs_addr/q_rt_addr                hazard query addresses
//   q_rs_pending/q_rt_pending          write pending to the queried reg
//   o_wb                               registered write port
// Optional: `define WB_LOAD_BYPASS_EN lets a load go straight to o_wb when
// the queue is empty and the ALU is idle.
module wb_merge_unit
   import wb_merge_unit_pkg::*;
#(
   parameter int LOAD_Q_DEPTH = 4,
   parameter int REG_ADDR_W   = WB_REG_ADDR_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   alu_valid,
   input  logic [REG_ADDR_W-1:0]  alu_rw_addr,
   input  logic [`DATA_WIDTH-1:0] alu_rw_data,
   input  logic                   mem_valid,
   output logic                   mem_ready,
   input  logic [REG_ADDR_W-1:0]  mem_rw_addr,
   input  logic [`DATA_WIDTH-1:0] mem_rw_data,
   input  logic [REG_ADDR_W-1:0]  q_rs_addr,
   input  logic [REG_ADDR_W-1:0]  q_rt_addr,
   output logic                   q_rs_pending,
   output logic                   q_rt_pending,
   output write_back_ifc          o_wb
);

   write_back_ifc                            r_wb;
   wb_entry_t                                w_head;
   wb_entry_t                                w_push_entry;
   logic                                     w_empty;
   logic                                     w_q_ready;
   logic                                     w_xfer;
   logic                                     w_bypass;
   logic                                     w_push;
   logic                                     w_pop;
   logic [LOAD_Q_DEPTH-1:0]                  w_live_vec;
   logic [LOAD_Q_DEPTH-1:0][REG_ADDR_W-1:0]  w_addr_vec;
   logic                                     w_rs_queued;
   logic                                     w_rt_queued;

   // Held low during reset so no transfer is ever signalled while the
   // count flops are being cleared.
   assign mem_ready = rst_n & w_q_ready;
   assign w_xfer    = mem_valid & mem_ready;

`ifdef WB_LOAD_BYPASS_EN
   assign w_bypass = w_xfer & w_empty & ~alu_valid;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_push = w_xfer & ~w_bypass;
   assign w_pop  = ~alu_valid & ~w_empty;

   assign w_push_entry.live = (mem_rw_addr != REG_ZERO);
   assign w_push_entry.addr = mem_rw_addr;
   assign w_push_entry.data = mem_rw_data;

   wb_load_queue #(
      .DEPTH (LOAD_Q_DEPTH)
   ) u_load_queue (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_push        (w_push),
      .i_push_entry  (w_push_entry),
      .i_pop         (w_pop),
      .i_squash_en   (alu_valid),
      .i_squash_addr (alu_rw_addr),
      .o_head        (w_head),
      .o_empty       (w_empty),
      .o_ready       (w_q_ready),
      .o_live_vec    (w_live_vec),
      .o_addr_vec    (w_addr_vec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb <= '0;
      end else if (alu_valid) begin
         r_wb.uses_rw <= (alu_rw_addr != REG_ZERO);
         r_wb.rw_addr <= alu_rw_addr;
         r_wb.rw_data <= alu_rw_data;
      end else if (w_pop) begin
         r_wb.uses_rw <= w_head.live;
         r_wb.rw_addr <= w_head.addr;
         r_wb.rw_data <= w_head.data;
      end else if (w_bypass) begin
         r_wb.uses_rw <= (mem_rw_addr != REG_ZERO);
         r_wb.rw_addr <= mem_rw_addr;
         r_wb.rw_data <= mem_rw_data;
      end else begin
         r_wb.uses_rw <= 1'b0;
      end
   end

   assign o_wb = r_wb;

   always_comb begin
      w_rs_queued = 1'b0;
      w_rt_queued = 1'b0;
      for (int i = 0; i < LOAD_Q_DEPTH; i++) begin
         if (w_live_vec[i] && (w_addr_vec[i] == q_rs_addr)) w_rs_queued = 1'b1;
         if (w_live_vec[i] && (w_addr_vec[i] == q_rt_addr)) w_rt_queued = 1'b1;
      end
   end

   assign q_rs_pending = (q_rs_addr != REG_ZERO) &
                         (w_rs_queued | (r_wb.uses_rw & (r_wb.rw_addr == q_rs_addr)));
   assign q_rt_pending = (q_rt_addr != REG_ZERO) &
                         (w_rt_queued | (r_wb.uses_rw & (r_wb.rw_addr == q_rt_addr)));

endmodule

// File: tb/tb_wb_merge_unit.sv
module tb_wb_merge_unit;
   import wb_merge_unit_pkg::*;

   logic                   clk;
   logic                   rst_n;
   logic                   alu_valid;
   logic [4:0]             alu_rw_addr;
   logic [`DATA_WIDTH-1:0] alu_rw_data;
   logic                   mem_valid;
   logic                   mem_ready;
   logic [4:0]             mem_rw_addr;
   logic [`DATA_WIDTH-1:0] mem_rw_data;
   logic [4:0]             q_rs_addr;
   logic [4:0]             q_rt_addr;
   logic                   q_rs_pending;
   logic                   q_rt_pending;
   write_back_ifc          o_wb;

   int n_vec;
   int n_err;
   logic [`DATA_WIDTH-1:0] rf_model [32];

   wb_merge_unit #(
      .LOAD_Q_DEPTH (4),
      .REG_ADDR_W   (5)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .alu_valid    (alu_valid),
      .alu_rw_addr  (alu_rw_addr),
      .alu_rw_data  (alu_rw_data),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .mem_rw_addr  (mem_rw_addr),
      .mem_rw_data  (mem_rw_data),
      .q_rs_addr    (q_rs_addr),
      .q_rt_addr    (q_rt_addr),
      .q_rs_pending (q_rs_pending),
      .q_rt_pending (q_rt_pending),
      .o_wb         (o_wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge, sample 1ns later, and retire any write into the
   // register-file model.
   task automatic step();
      @(posedge clk);
      #1;
      if (o_wb.uses_rw === 1'b1) rf_model[o_wb.rw_addr] = o_wb.rw_data;
   endtask

   task automatic alu(input logic v, input logic [4:0] a, input logic [31:0] d);
      alu_valid   = v;
      alu_rw_addr = a;
      alu_rw_data = d;
   endtask

   task automatic mem(input logic v, input logic [4:0] a, input logic [31:0] d);
      mem_valid   = v;
      mem_rw_addr = a;
      mem_rw_data = d;
   endtask

   task automatic chk_wb(input string tag, input logic u, input logic [4:0] a, input logic [31:0] d);
      chk({tag, ".uses"}, 64'(o_wb.uses_rw), 64'(u));
      chk({tag, ".addr"}, 64'(o_wb.rw_addr), 64'(a));
      chk({tag, ".data"}, 64'(o_wb.rw_data), 64'(d));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      for (int i = 0; i < 32; i++) rf_model[i] = '0;
      rst_n = 1'b0;
      alu(0, 0, 0);
      mem(0, 0, 0);
      q_rs_addr = 0;
      q_rt_addr = 0;

      // reset state
      #12;
      chk_wb("rst", 0, 0, 0);
      chk("rst.mem_ready", 64'(mem_ready), 0);
      q_rs_addr = 3;
      q_rt_addr = 4;
      #1;
      chk("rst.rs_pend", 64'(q_rs_pending), 0);
      chk("rst.rt_pend", 64'(q_rt_pending), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // ALU only
      alu(1, 3, 32'hDEADBEEF);
      step();
      chk_wb("alu1", 1, 3, 32'hDEADBEEF);
      alu(0, 0, 0);
      q_rs_addr = 3;
      #1;
      chk("alu1.pend", 64'(q_rs_pending), 1);
      step();
      chk_wb("alu1.idle", 0, 3, 32'hDEADBEEF);
      chk("alu1.pend_clr", 64'(q_rs_pending), 0);

      // loads under ALU pressure
      alu(1, 7, 32'h70);
      mem(1, 4, 32'h11);
      #1;
      chk("pres.ready", 64'(mem_ready), 1);
      step();
      chk_wb("pres.a0", 1, 7, 32'h70);
      alu(1, 7, 32'h71);
      mem(1, 5, 32'h22);
      step();
      chk_wb("pres.a1", 1, 7, 32'h71);
      alu(1, 7, 32'h72);
      mem(0, 0, 0);
      q_rs_addr = 5;
      q_rt_addr = 4;
      #1;
      chk("pres.rs5", 64'(q_rs_pending), 1);
      chk("pres.rt4", 64'(q_rt_pending), 1);
      step();
      chk_wb("pres.a2", 1, 7, 32'h72);
      alu(0, 0, 0);
      step();
      chk_wb("pres.l4", 1, 4, 32'h11);
      chk("pres.rs5b", 64'(q_rs_pending), 1);
      step();
      chk_wb("pres.l5", 1, 5, 32'h22);
      chk("pres.rs5c", 64'(q_rs_pending), 1);
      step();
      chk("pres.idle", 64'(o_wb.uses_rw), 0);
      chk("pres.rs5d", 64'(q_rs_pending), 0);

      // full queue / back-pressure
      alu(1, 9, 32'h90);
      for (int i = 0; i < 4; i++) begin
         mem(1, 5'(10 + i), 32'hA0 + 32'(i));
         #1;
         chk($sformatf("full.ready%0d", i), 64'(mem_ready), 1);
         step();
      end
      mem(1, 14, 32'hA4);
      #1;
      chk("full.ready4", 64'(mem_ready), 0);
      step();
      chk("full.ready4b", 64'(mem_ready), 0);
      alu(0, 0, 0);
      #1;
      chk("full.pop_same", 64'(mem_ready), 0);
      step();
      chk_wb("full.l10", 1, 10, 32'hA0);
      chk("full.ready_after", 64'(mem_ready), 1);
      step();
      mem(0, 0, 0);
      chk_wb("full.l11", 1, 11, 32'hA1);
      step();
      chk_wb("full.l12", 1, 12, 32'hA2);
      step();
      chk_wb("full.l13", 1, 13, 32'hA3);
      step();
      chk_wb("full.l14", 1, 14, 32'hA4);
      step();
      chk("full.drained", 64'(o_wb.uses_rw), 0);

      // squash, separate cycles
      alu(1, 8, 32'h80);
      mem(1, 6, 32'hAA);
      step();
      alu(1, 6, 32'hBB);
      mem(0, 0, 0);
      q_rs_addr = 6;
      #1;
      chk("sq.pend", 64'(q_rs_pending), 1);
      step();
      chk_wb("sq.alu", 1, 6, 32'hBB);
      alu(0, 0, 0);
      step();
      chk("sq.slot", 64'(o_wb.uses_rw), 0);
      chk("sq.pend_clr", 64'(q_rs_pending), 0);
      chk("sq.rf6", 64'(rf_model[6]), 64'hBB);

      // squash, same cycle
      alu(1, 6, 32'hBB);
      mem(1, 6, 32'hAA);
      step();
      chk_wb("sq2.alu", 1, 6, 32'hBB);
      alu(0, 0, 0);
      mem(0, 0, 0);
      step();
      chk("sq2.slot", 64'(o_wb.uses_rw), 0);
      chk("sq2.rf6", 64'(rf_model[6]), 64'hBB);
      step();

      // register zero
      alu(1, 0, 32'h55);
      mem(1, 0, 32'h66);
      q_rs_addr = 0;
      step();
      chk("r0.alu", 64'(o_wb.uses_rw), 0);
      chk("r0.pend", 64'(q_rs_pending), 0);
      alu(0, 0, 0);
      mem(0, 0, 0);
      step();
      chk("r0.load", 64'(o_wb.uses_rw), 0);
      chk("r0.pend2", 64'(q_rs_pending), 0);
      step();

      // reset mid-operation
      alu(1, 9, 32'h99);
      for (int i = 0; i < 3; i++) begin
         mem(1, 5'(1 + i), 32'hC0 + 32'(i));
         step();
      end
      alu(0, 0, 0);
      mem(0, 0, 0);
      q_rs_addr = 1;
      #2;
      rst_n = 1'b0;
      #1;
      chk_wb("mid.rst", 0, 0, 0);
      chk("mid.ready", 64'(mem_ready), 0);
      chk("mid.pend", 64'(q_rs_pending), 0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int stale;
         stale = 0;
         for (int i = 0; i < 5; i++) begin
            step();
            if (o_wb.uses_rw !== 1'b0) stale++;
         end
         chk("mid.no_stale", 64'(stale), 0);
      end
      chk("mid.ready_rel", 64'(mem_ready), 1);

      // idle load latency
      mem(1, 12, 32'h77);
      step();
      mem(0, 0, 0);
`ifdef WB_LOAD_BYPASS_EN
      chk_wb("lat.bypass", 1, 12, 32'h77);
      step();
      chk("lat.after", 64'(o_wb.uses_rw), 0);
`else
      chk("lat.enq", 64'(o_wb.uses_rw), 0);
      step();
      chk_wb("lat.pop", 1, 12, 32'h77);
`endif
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
